// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store sequencer and its data memory port.
// Memory strobe encoding is active-low for writes: DM_READ=1, DM_WRITE=0.
package load_store_unit_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int DM_DEPTH = 12;

  localparam logic DM_READ  = 1'b1;
  localparam logic DM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_SETUP = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // Unsigned, full-width compare against the implemented depth.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage (master) and the load/store unit (slave).
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: one request at a time, range check, glitch-free memory strobe
// (address/data settle a cycle before the one-cycle write pulse), registered response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH = DM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_writedata,
  output logic              dm_mem_write,
  input  logic [DATA_W-1:0] dm_readdata,
  output logic [7:0]        err_count
);

  lsu_state_t        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] dm_address_q, dm_address_d;
  logic [DATA_W-1:0] dm_writedata_q, dm_writedata_d;
  logic              dm_mem_write_q, dm_mem_write_d;
  logic [7:0]        err_count_q, err_count_d;

  logic accept;
  logic addr_ok;

  assign accept  = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;
  assign addr_ok = addr_in_range(bus.req_addr, DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!addr_ok)          state_d = ST_RESP;
          else if (bus.req_write) state_d = ST_SETUP;
          else                   state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_RESP;
      ST_SETUP: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Every output is a flop; its next value is derived from the next state.
  always_comb begin
    dm_address_d   = dm_address_q;
    dm_writedata_d = dm_writedata_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    err_count_d    = err_count_q;

    if (accept) begin
      dm_address_d   = bus.req_addr;
      dm_writedata_d = bus.req_wdata;
      rsp_rdata_d    = '0;
      rsp_err_d      = !addr_ok;
      if (!addr_ok && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    if (state_q == ST_READ) begin
      rsp_rdata_d = dm_readdata;
    end

    req_ready_d    = (state_d == ST_IDLE);
    rsp_valid_d    = (state_d == ST_RESP);
    dm_mem_write_d = (state_d == ST_WRITE) ? DM_WRITE : DM_READ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      dm_address_q   <= '0;
      dm_writedata_q <= '0;
      dm_mem_write_q <= DM_READ;
      err_count_q    <= '0;
    end else begin
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      dm_address_q   <= dm_address_d;
      dm_writedata_q <= dm_writedata_d;
      dm_mem_write_q <= dm_mem_write_d;
      err_count_q    <= err_count_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dm_address    = dm_address_q;
  assign dm_writedata  = dm_writedata_q;
  assign dm_mem_write  = dm_mem_write_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 12-word memory model initialised DM[i]=i.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dm_address;
  logic [7:0]  dm_writedata;
  logic        dm_mem_write;
  logic [7:0]  dm_readdata;
  logic [7:0]  err_count;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dm_address   (dm_address),
    .dm_writedata (dm_writedata),
    .dm_mem_write (dm_mem_write),
    .dm_readdata  (dm_readdata),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Level-sensitive memory: combinational read, write while strobe is low.
  logic [7:0] dm [0:11];
  int         wr_low_cycles;
  logic [7:0] wr_addr_seen;

  assign dm_readdata = (dm_address < 8'd12) ? dm[dm_address[3:0]] : 8'h00;

  always @(negedge clk) begin
    if (dm_mem_write == 1'b0) begin
      wr_low_cycles = wr_low_cycles + 1;
      wr_addr_seen  = dm_address;
      if (dm_address < 8'd12) dm[dm_address[3:0]] = dm_writedata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure accept-to-rsp_valid latency, check the response.
  // With rsp_ready high, also check the return to IDLE one edge later.
  task automatic send(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [7:0] wdata, input int exp_lat,
                      input logic [7:0] exp_rdata, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
    check({tag, "/err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, "/busy"}, 32'(bus.req_ready), 32'd0);
    $display("txn %s wr=%0b addr=0x%02h wdata=0x%02h lat=%0d rdata=0x%02h err=%0b err_count=%0d",
             tag, wr, addr, wdata, lat, bus.rsp_rdata, bus.rsp_err, err_count);
    if (bus.rsp_ready) begin
      @(posedge clk);
      #1;
      check({tag, "/rsp_done"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "/idle"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 12; i++) dm[i] = 8'(i);
    wr_low_cycles = 0;
    wr_addr_seen  = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst/rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst/dm_address", 32'(dm_address), 32'd0);
    check("rst/dm_writedata", 32'(dm_writedata), 32'd0);
    check("rst/dm_mem_write", 32'(dm_mem_write), 32'd1);
    check("rst/err_count", 32'(err_count), 32'd0);

    wr_low_cycles = 0;
    send("load5", 1'b0, 8'd5, 8'h00, 2, 8'h05, 1'b0);
    check("load5/no_write", 32'(wr_low_cycles), 32'd0);

    wr_low_cycles = 0;
    send("store3", 1'b1, 8'd3, 8'hA7, 3, 8'h00, 1'b0);
    check("store3/pulse_len", 32'(wr_low_cycles), 32'd1);
    check("store3/pulse_addr", 32'(wr_addr_seen), 32'd3);
    send("load3", 1'b0, 8'd3, 8'h00, 2, 8'hA7, 1'b0);
    send("load2", 1'b0, 8'd2, 8'h00, 2, 8'h02, 1'b0);
    send("load4", 1'b0, 8'd4, 8'h00, 2, 8'h04, 1'b0);

    wr_low_cycles = 0;
    send("err12", 1'b0, 8'd12, 8'h00, 1, 8'h00, 1'b1);
    send("errFF", 1'b0, 8'hFF, 8'h00, 1, 8'h00, 1'b1);
    check("err/no_write", 32'(wr_low_cycles), 32'd0);
    check("err/err_count", 32'(err_count), 32'd2);
    send("store_err", 1'b1, 8'd12, 8'h3C, 1, 8'h00, 1'b1);
    check("store_err/no_write", 32'(wr_low_cycles), 32'd0);
    check("store_err/err_count", 32'(err_count), 32'd3);

    // Backpressure on the highest valid address.
    bus.rsp_ready = 1'b0;
    send("load11_bp", 1'b0, 8'd11, 8'h00, 2, 8'h0B, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp/rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp/rsp_rdata", 32'(bus.rsp_rdata), 32'h0B);
      check("bp/req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp/rsp_released", 32'(bus.rsp_valid), 32'd0);
    check("bp/idle", 32'(bus.req_ready), 32'd1);

    // Reset while the write strobe is low.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'd7;
    bus.req_wdata = 8'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rstw/strobe_low", 32'(dm_mem_write), 32'd0);
    rst = 1'b1;
    #1;
    check("rstw/dm_mem_write", 32'(dm_mem_write), 32'd1);
    check("rstw/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstw/req_ready", 32'(bus.req_ready), 32'd1);
    check("rstw/dm_address", 32'(dm_address), 32'd0);
    check("rstw/dm_writedata", 32'(dm_writedata), 32'd0);
    check("rstw/err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rstw/no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("rstw/mem7", 32'(dm[7]), 32'd7);
    $display("txn rst_mid_write addr=0x07 wdata=0x55 dropped mem7=0x%02h", dm[7]);

    // Saturation of the error counter.
    for (int i = 0; i < 256; i++) begin
      send("sat", 1'b0, 8'(12 + (i % 244)), 8'h00, 1, 8'h00, 1'b1);
      if (i == 253) check("sat/254", 32'(err_count), 32'hFE);
      if (i == 254) check("sat/255", 32'(err_count), 32'hFF);
    end
    check("sat/256", 32'(err_count), 32'hFF);
    send("post_sat_load0", 1'b0, 8'd0, 8'h00, 2, 8'h00, 1'b0);
    check("post_sat/err_count", 32'(err_count), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
